microsequencer: RTL
===================

Name: microsequencer

Overview:
- Parametrised successor to the fixed-step SAP-1.5 control path. It owns the microstep counter and drives the control word into the bus/register datapath.
- Adds variable-length instructions via a last-step bit, conditional abort on a selected flag, memory-ready stalling with a watchdog, halt with resume, and a retired-instruction counter.
- Microcode ROM is external and combinational. This block presents the ROM address and post-processes the returned word.

Parameters:
OPCODE_WIDTH, 4, opcode bits from instruction register
STEP_WIDTH, 3, microstep counter width (max 2**STEP_WIDTH steps per instruction)
CW_WIDTH, 24, datapath control word width
FLAG_COUNT, 3, flag inputs (Z,C,N order, bit0=Z); must be <=4
STALL_LIMIT, 15, consecutive not-ready cycles before timeout (>=1)
COUNT_WIDTH, 16, retired-instruction counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode_i  in  OPCODE_WIDTH  current IR opcode
flags_i  in  FLAG_COUNT  latched flags register
ucode_addr_o  out  OPCODE_WIDTH+STEP_WIDTH  {opcode_i, step}
ucode_word_i  in  CW_WIDTH+7  ROM data, combinational from ucode_addr_o
mem_ready_i  in  1  memory access completes this cycle
resume_i  in  1  leave HALTED (level, sampled in HALTED only)
control_word_o  out  CW_WIDTH  gated datapath control word
mem_req_o  out  1  current step requests memory
step_o  out  STEP_WIDTH  current microstep
stall_o  out  1  sequencer stalled this cycle
instr_done_o  out  1  one-cycle pulse, instruction retired
halted_o  out  1  in HALTED
ucode_err_o  out  1  sticky: step overflow without last bit
timeout_o  out  1  sticky: stall watchdog expired
instr_count_o  out  COUNT_WIDTH  retired instructions, wraps

Behaviour:
- ucode_word_i fields, W=CW_WIDTH+7:
  - [W-1] last
  - [W-2] halt
  - [W-3] mem
  - [W-4] cond_en
  - [W-5] cond_pol
  - [W-6:W-7] cond_sel
  - [CW_WIDTH-1:0] cw
- Reset (async, reset=0):
  - state RUN, step=0, stall counter=0.
  - All sticky/count outputs 0.
  - control_word_o, mem_req_o, stall_o, instr_done_o forced 0 while reset is low.
- States: RUN, HALTED. Stall is a RUN sub-condition, not a separate state.
- RUN, evaluated combinationally each cycle, priority high to low:
  1. halt=1: control_word_o=0. Next state HALTED, step=0. instr_done_o=1 this cycle; the HALT instruction counts as retired.
  2. cond_en=1 and flags_i[cond_sel]!=cond_pol: control_word_o=0. step=0 next. instr_done_o=1. The remaining steps of the instruction are skipped.
  3. mem=1 and mem_ready_i=0: control_word_o=0, mem_req_o=1, stall_o=1. step holds. Stall counter +1.
     - When the counter reaches STALL_LIMIT: timeout_o set, next state HALTED.
  4. Otherwise: control_word_o=cw, mem_req_o=mem, stall counter cleared.
     - last=1: step=0 next, instr_done_o=1.
     - step == all-ones with last=0: step wraps to 0, ucode_err_o set, instr_done_o=1.
     - Else: step+1.
- Stall counter clears on any non-stall RUN cycle.
- instr_count_o increments by 1 on every instr_done_o cycle and wraps modulo 2**COUNT_WIDTH.
- HALTED:
  - control_word_o=0, mem_req_o=0, halted_o=1. ucode_addr_o = {opcode_i, 0}.
  - resume_i=1 → RUN, step=0, halted_o=0 next cycle. timeout_o and ucode_err_o are cleared on resume.
- halted_o is registered: it rises the cycle after the halt or timeout cycle.
- Reset asserted mid-stall or mid-instruction aborts immediately. No pulse and no count.
- opcode_i may change only on step 0. The block does not re-latch it.
- Latency: control_word_o is combinational from the ROM within the same cycle as step.

Test Plan:
- 3-step instr (last on step 2), mem never used → cw emitted on steps 0,1,2. instr_done_o high on the step-2 cycle. instr_count_o=1. step_o sequence 0,1,2,0.
- Step 1 has mem=1, mem_ready_i low 4 cycles then high → stall_o high 4 cycles, control_word_o=0 and step_o=1 throughout, mem_req_o=1. cw appears on cycle 5. timeout_o stays 0.
- Same as the stall case with STALL_LIMIT=3 and ready never high → timeout_o=1 after 3 stall cycles. halted_o=1 next cycle. resume_i pulse → RUN, step 0, timeout_o=0.
- cond_en=1, cond_sel=0 (Z), cond_pol=1 on step 2 of a 4-step jump, flags_i=3'b000 → control_word_o=0 that cycle. step returns to 0. instr_done_o=1. With flags_i=3'b001 → cw emitted and the instruction runs 4 steps.
- Microcode with last never set, STEP_WIDTH=3 → 8 steps emitted, wrap to 0, ucode_err_o=1, instr_count_o=1.
- halt on step 2, then reset low mid-HALTED; separately, reset low during a stall → all outputs 0, step_o=0, instr_count_o=0. After release the next fetch starts at step 0.

Source files
------------

// File: rtl/microsequencer.sv
// Microstep sequencer: walks external microcode per opcode and gates the returned
// control word for conditional abort, memory stall/watchdog, halt/resume and step overflow.
module microsequencer #(
    parameter int unsigned OPCODE_WIDTH = 4,
    parameter int unsigned STEP_WIDTH   = 3,
    parameter int unsigned CW_WIDTH     = 24,
    parameter int unsigned FLAG_COUNT   = 3,
    parameter int unsigned STALL_LIMIT  = 15,
    parameter int unsigned COUNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [OPCODE_WIDTH-1:0]        opcode_i,
    input  logic [FLAG_COUNT-1:0]          flags_i,
    output logic [OPCODE_WIDTH+STEP_WIDTH-1:0] ucode_addr_o,
    input  logic [CW_WIDTH+6:0]            ucode_word_i,
    input  logic                           mem_ready_i,
    input  logic                           resume_i,
    output logic [CW_WIDTH-1:0]            control_word_o,
    output logic                           mem_req_o,
    output logic [STEP_WIDTH-1:0]          step_o,
    output logic                           stall_o,
    output logic                           instr_done_o,
    output logic                           halted_o,
    output logic                           ucode_err_o,
    output logic                           timeout_o,
    output logic [COUNT_WIDTH-1:0]         instr_count_o
);

    localparam int unsigned WORD_W = CW_WIDTH + 7;
    localparam int unsigned SC_W   = $clog2(STALL_LIMIT + 1);

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [STEP_WIDTH-1:0]  step_q, step_d, addr_step;
    logic [SC_W-1:0]        stall_cnt_q, stall_cnt_d, stall_inc;
    logic                   err_q, err_d;
    logic                   timeout_q, timeout_d;
    logic [COUNT_WIDTH-1:0] count_q;

    logic                   w_last, w_halt, w_mem, w_cond_en, w_cond_pol;
    logic [1:0]             w_cond_sel;
    logic [CW_WIDTH-1:0]    w_cw;
    logic [3:0]             flags_ext;
    logic                   cond_fail;

    logic [CW_WIDTH-1:0]    cw_c;
    logic                   req_c, stall_c, done_c;

    // Microcode word fields
    assign w_last     = ucode_word_i[WORD_W-1];
    assign w_halt     = ucode_word_i[WORD_W-2];
    assign w_mem      = ucode_word_i[WORD_W-3];
    assign w_cond_en  = ucode_word_i[WORD_W-4];
    assign w_cond_pol = ucode_word_i[WORD_W-5];
    assign w_cond_sel = ucode_word_i[WORD_W-6 -: 2];
    assign w_cw       = ucode_word_i[CW_WIDTH-1:0];

    // Selects beyond FLAG_COUNT read as 0
    assign flags_ext = 4'(flags_i);
    assign cond_fail = w_cond_en && (flags_ext[w_cond_sel] != w_cond_pol);
    assign stall_inc = stall_cnt_q + SC_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_RUN;
            step_q      <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
            count_q     <= count_q + COUNT_WIDTH'(done_c);
        end
    end

    // Next-state and per-cycle step outcome, highest-priority condition first
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        stall_cnt_d = stall_cnt_q;
        err_d       = err_q;
        timeout_d   = timeout_q;
        cw_c        = '0;
        req_c       = 1'b0;
        stall_c     = 1'b0;
        done_c      = 1'b0;
        case (state_q)
            S_RUN: begin
                if (w_halt) begin
                    done_c      = 1'b1;
                    state_d     = S_HALTED;
                    step_d      = '0;
                    stall_cnt_d = '0;
                end else if (cond_fail) begin
                    done_c      = 1'b1;
                    step_d      = '0;
                    stall_cnt_d = '0;
                end else if (w_mem && !mem_ready_i) begin
                    req_c       = 1'b1;
                    stall_c     = 1'b1;
                    stall_cnt_d = stall_inc;
                    if (stall_inc == SC_W'(STALL_LIMIT)) begin
                        timeout_d   = 1'b1;
                        state_d     = S_HALTED;
                        step_d      = '0;
                        stall_cnt_d = '0;
                    end
                end else begin
                    cw_c        = w_cw;
                    req_c       = w_mem;
                    stall_cnt_d = '0;
                    if (w_last) begin
                        done_c = 1'b1;
                        step_d = '0;
                    end else if (step_q == '1) begin
                        done_c = 1'b1;
                        step_d = '0;
                        err_d  = 1'b1;
                    end else begin
                        step_d = step_q + STEP_WIDTH'(1);
                    end
                end
            end
            S_HALTED: begin
                if (resume_i) begin
                    state_d   = S_RUN;
                    step_d    = '0;
                    err_d     = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // Combinational outputs are held quiet while reset is asserted
    assign addr_step      = (state_q == S_HALTED) ? STEP_WIDTH'(0) : step_q;
    assign ucode_addr_o   = {opcode_i, addr_step};
    assign control_word_o = reset ? cw_c : '0;
    assign mem_req_o      = reset & req_c;
    assign stall_o        = reset & stall_c;
    assign instr_done_o   = reset & done_c;
    assign step_o         = step_q;
    assign halted_o       = (state_q == S_HALTED);
    assign ucode_err_o    = err_q;
    assign timeout_o      = timeout_q;
    assign instr_count_o  = count_q;

endmodule
